// File: rtl/line_window_if.sv
// Pixel-in / window-out bundle between the capture side, the line-window
// sequencer and the downstream convolution stage.
interface line_window_if #(
  parameter int DW = 12,
  parameter int CW = 10
);
  logic          pix_valid;
  logic          pix_sof;
  logic [DW-1:0] pix_data;
  logic          shift_en;
  logic [DW-1:0] shift_data;
  logic          win_valid;
  logic [CW-1:0] win_x;
  logic [CW-1:0] win_y;
  logic          frame_done;
  logic          resync;

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  shift_en, shift_data, win_valid, win_x, win_y, frame_done, resync
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output shift_en, shift_data, win_valid, win_x, win_y, frame_done, resync
  );
endinterface

// File: rtl/line_window_seq.sv
// Line-buffer sequencer for the 3x3 window: raster position tracking and window flags.
// Optional frame/resync statistics counters: define LINE_WINDOW_SEQ_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for an SOF pixel; other pixels are dropped
// ACTIVE | inside a frame, accepting pixels at (col_q,row_q)
// DONE   | last pixel taken; frame_done pulses on the following cycle
module line_window_seq #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 12,
  parameter int CW    = 10
) (
  input  logic         clk,
  input  logic         rst,
  line_window_if.slave lw
`ifdef LINE_WINDOW_SEQ_STATS_EN
  ,
  output logic [15:0]  frame_cnt_o,
  output logic [15:0]  resync_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_x_q, win_x_d;
  logic [CW-1:0] win_y_q, win_y_d;
  logic          frame_done_q, frame_done_d;
  logic          resync_q, resync_d;
  logic          accept;
  logic [CW-1:0] pix_c, pix_r;
  logic [DW-1:0] pix_data_w;

  always_comb begin
    accept       = lw.pix_valid & ((state_q == ACTIVE) | lw.pix_sof);
    pix_c        = lw.pix_sof ? '0 : col_q;
    pix_r        = lw.pix_sof ? '0 : row_q;
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    frame_done_d = (state_q == DONE);
    resync_d     = accept & lw.pix_sof & (state_q == ACTIVE);

    if (state_q == DONE) state_d = IDLE;

    if (accept) begin
      // window flags line up with the buffer contents after this same edge
      win_valid_d = (pix_c >= TWO) && (pix_r >= TWO);
      win_x_d     = pix_c - ONE;
      win_y_d     = pix_r - ONE;
      if (lw.pix_sof) begin
        state_d = ACTIVE;
        col_d   = ONE;
        row_d   = '0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = DONE;
        end else begin
          row_d = row_q + ONE;
        end
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      frame_done_q <= 1'b0;
      resync_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      frame_done_q <= frame_done_d;
      resync_q     <= resync_d;
    end
  end

  assign pix_data_w    = lw.pix_data;
  assign lw.shift_en   = accept;
  assign lw.shift_data = pix_data_w;
  assign lw.win_valid  = win_valid_q;
  assign lw.win_x      = win_x_q;
  assign lw.win_y      = win_y_q;
  assign lw.frame_done = frame_done_q;
  assign lw.resync     = resync_q;

`ifdef LINE_WINDOW_SEQ_STATS_EN
  logic [15:0] frame_cnt_q, resync_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q  <= '0;
      resync_cnt_q <= '0;
    end else begin
      if (frame_done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (resync_q && (resync_cnt_q != 16'hFFFF)) resync_cnt_q <= resync_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o  = frame_cnt_q;
  assign resync_cnt_o = resync_cnt_q;
`endif

endmodule

// File: tb/tb_line_window_seq.sv
// Bench for line_window_seq: raster-index reference model checked every cycle,
// plus literal expectations for the small 8x6 frame.
module tb_line_window_seq;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 12;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_window_if #(.DW(DW), .CW(CW)) lw ();

`ifdef LINE_WINDOW_SEQ_STATS_EN
  logic [15:0] frame_cnt, resync_cnt;
`endif

  line_window_seq #(.IMG_W(W), .IMG_H(H), .DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .lw  (lw)
`ifdef LINE_WINDOW_SEQ_STATS_EN
    ,
    .frame_cnt_o  (frame_cnt),
    .resync_cnt_o (resync_cnt)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: position is a flat raster index within the frame
  bit m_active = 0;
  int m_idx = 0;
  bit m_pend_fd = 0;
  bit e_wv = 0, e_fd = 0, e_rs = 0;
  int e_wx = 0, e_wy = 0;
  bit chk_on = 0;
  bit prev_v = 0;

  // observation tallies
  int ncyc = 0;
  int win_cnt, fd_cnt, rs_cnt, se_cnt;
  int first_x, first_y, last_x, last_y, first_cyc, last_win_cyc, fd_cyc;
  bit have_first;
  int acc_cyc;

  task automatic clr_tally();
    win_cnt = 0; fd_cnt = 0; rs_cnt = 0; se_cnt = 0;
    have_first = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    first_cyc = -1; last_win_cyc = -1; fd_cyc = -1; acc_cyc = -1;
  endtask

  initial begin
    int c, r;
    bit acc;
    forever begin
      @(negedge clk);
      ncyc++;
      if (chk_on) begin
        chk("win_valid", lw.win_valid, e_wv);
        chk("win_x", lw.win_x, e_wx);
        chk("win_y", lw.win_y, e_wy);
        chk("frame_done", lw.frame_done, e_fd);
        chk("resync", lw.resync, e_rs);
        chk("shift_en", lw.shift_en, lw.pix_valid && (m_active || lw.pix_sof));
        chk("shift_data", lw.shift_data, lw.pix_data);
        if (!prev_v) chk("win_after_gap", lw.win_valid, 0);
        if (lw.win_valid === 1'b1) begin
          win_cnt++;
          if (!have_first) begin
            have_first = 1; first_x = lw.win_x; first_y = lw.win_y; first_cyc = ncyc;
          end
          last_x = lw.win_x; last_y = lw.win_y; last_win_cyc = ncyc;
        end
        if (lw.frame_done === 1'b1) begin fd_cnt++; fd_cyc = ncyc; end
        if (lw.resync === 1'b1) rs_cnt++;
        if (lw.shift_en === 1'b1) se_cnt++;
      end
      // advance the model with the inputs the next rising edge will sample
      prev_v = lw.pix_valid;
      if (!rst) begin
        m_active = 0; m_idx = 0; m_pend_fd = 0;
        e_wv = 0; e_wx = 0; e_wy = 0; e_fd = 0; e_rs = 0;
        chk_on = 1;
      end else begin
        e_fd = m_pend_fd;
        m_pend_fd = 0;
        e_rs = 0;
        acc = lw.pix_valid && (m_active || lw.pix_sof);
        if (acc) begin
          if (lw.pix_sof) begin
            c = 0; r = 0;
            e_rs = m_active;
            m_active = 1;
            m_idx = 1;
          end else begin
            c = m_idx % W;
            r = m_idx / W;
            m_idx++;
            if (m_idx == W * H) begin
              m_active = 0; m_idx = 0; m_pend_fd = 1;
            end
          end
          e_wv = (c >= 2) && (r >= 2);
          e_wx = (c - 1) & ((1 << CW) - 1);
          e_wy = (r - 1) & ((1 << CW) - 1);
        end else begin
          e_wv = 0;
        end
      end
    end
  end

  task automatic cyc(input bit v, input bit s);
    lw.pix_valid = v;
    lw.pix_sof   = s;
    lw.pix_data  = DW'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic pixels(input int n, input bit sof_first, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, sof_first && (i == 0));
      if (i == 2 * W + 2) acc_cyc = ncyc;
      repeat (gap) cyc(1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic rand_frame();
    int k;
    cyc(1'b1, 1'b1);
    for (int i = 1; i < W * H; i++) begin
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom_range(0, 1)));
      k = $urandom_range(0, 99);
      if (k == 0) begin
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        rst = 1'b1;
      end else if (k == 1) begin
        cyc(1'b1, 1'b1);
      end else begin
        cyc(1'b1, 1'b0);
      end
    end
    repeat ($urandom_range(0, 3)) cyc(1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    lw.pix_valid = 1'b0;
    lw.pix_sof   = 1'b0;
    lw.pix_data  = '0;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_win_valid", lw.win_valid, 0);
    chk("rst_win_x", lw.win_x, 0);
    chk("rst_win_y", lw.win_y, 0);
    chk("rst_frame_done", lw.frame_done, 0);
    chk("rst_resync", lw.resync, 0);
    @(posedge clk); #1;

    // continuous full frame
    clr_tally();
    pixels(W * H, 1'b1, 0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("t1_win_cnt", win_cnt, 24);
    chk("t1_first_x", first_x, 1);
    chk("t1_first_y", first_y, 1);
    chk("t1_first_lat", first_cyc - acc_cyc, 1);
    chk("t1_last_x", last_x, 6);
    chk("t1_last_y", last_y, 4);
    chk("t1_fd_cnt", fd_cnt, 1);
    chk("t1_fd_lat", fd_cyc - last_win_cyc, 1);

    // same frame with 1,0,0 valid pattern
    clr_tally();
    pixels(W * H, 1'b1, 2);
    repeat (3) cyc(1'b0, 1'b0);
    chk("t2_win_cnt", win_cnt, 24);
    chk("t2_first_x", first_x, 1);
    chk("t2_first_y", first_y, 1);
    chk("t2_last_x", last_x, 6);
    chk("t2_last_y", last_y, 4);
    chk("t2_fd_cnt", fd_cnt, 1);

    // non-SOF pixels from reset are dropped
    do_reset();
    clr_tally();
    pixels(10, 1'b0, 0);
    chk("t3_shift_cnt", se_cnt, 0);
    chk("t3_win_cnt", win_cnt, 0);
    lw.pix_valid = 1'b1;
    lw.pix_sof   = 1'b1;
    #1;
    chk("t3_sof_shift_en", lw.shift_en, 1);
    @(posedge clk); #1;
    pixels(W * H - 1, 1'b0, 0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("t3_fd_cnt", fd_cnt, 1);

    // SOF injected at (3,4)
    clr_tally();
    pixels(4 * W + 3, 1'b1, 0);
    pixels(W * H, 1'b1, 0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("t4_rs_cnt", rs_cnt, 1);
    chk("t4_fd_cnt", fd_cnt, 1);
    chk("t4_win_cnt", win_cnt, 13 + 24);

    // one-cycle reset at (5,3)
    clr_tally();
    pixels(3 * W + 5, 1'b1, 0);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    rst = 1'b1;
    lw.pix_valid = 1'b1;
    lw.pix_sof   = 1'b0;
    @(negedge clk);
    chk("t5_win_valid", lw.win_valid, 0);
    chk("t5_win_x", lw.win_x, 0);
    chk("t5_win_y", lw.win_y, 0);
    chk("t5_frame_done", lw.frame_done, 0);
    chk("t5_resync", lw.resync, 0);
    chk("t5_idle_shift_en", lw.shift_en, 0);
    @(posedge clk); #1;
    clr_tally();
    pixels(12, 1'b0, 0);
    chk("t5_drop_shift_cnt", se_cnt, 0);
    chk("t5_drop_win_cnt", win_cnt, 0);
    pixels(W * H, 1'b1, 0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("t5_win_cnt", win_cnt, 24);
    chk("t5_fd_cnt", fd_cnt, 1);

    // randomized frames: gaps, stray SOF, mid-frame resets, back-to-back SOF
    for (int f = 0; f < 10; f++) rand_frame();
    repeat (3) cyc(1'b0, 1'b0);

`ifdef LINE_WINDOW_SEQ_STATS_EN
    do_reset();
    for (int f = 0; f < 3; f++) begin
      pixels(W * H, 1'b1, 0);
      repeat (2) cyc(1'b0, 1'b0);
    end
    pixels(20, 1'b1, 0);
    pixels(5, 1'b1, 0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("stats_frame_cnt", frame_cnt, 3);
    chk("stats_resync_cnt", resync_cnt, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
